// File: rtl/ex_pkg.sv
// Shared encodings and default latencies for the EX-stage sequencing controller.
package ex_pkg;

  localparam logic [1:0] OP_SINGLE = 2'b00;
  localparam logic [1:0] OP_MUL    = 2'b01;
  localparam logic [1:0] OP_DIV    = 2'b10;
  localparam logic [1:0] OP_REM    = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } ex_state_e;

  localparam int MUL_LAT_D = 4;
  localparam int DIV_LAT_D = 33;

endpackage

// File: rtl/ex_lat_counter.sv
// Loadable down-counter with clear, load, saturating decrement and zero flag.
module ex_lat_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ex_mc_ctrl.sv
// EX-stage sequencer: completes single-cycle ops, launches MUL/DIV/REM on the
// shared iterative unit, counts its latency and handles flush and MEM stalls.
module ex_mc_ctrl
  import ex_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_D,
  parameter int DIV_LAT = DIV_LAT_D,
  parameter int CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid_i,
  input  logic [1:0] id_op_i,
  input  logic       flush_i,
  input  logic       mem_stall_i,
  output logic       ex_stall_o,
  output logic       busy_o,
  output logic       unit_start_o,
  output logic       unit_sel_o,
  output logic       unit_abort_o,
  output logic       result_capture_o,
  output logic       ex_valid_o
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  ex_state_e        state_q, state_d;
  logic             unit_start_q, unit_start_d;
  logic             unit_sel_q, unit_sel_d;
  logic             unit_abort_q, unit_abort_d;
  logic             ex_valid_q, ex_valid_d;
  logic             capture;
  logic             accept;
  logic             cnt_clear, cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;

  assign accept = (state_q == IDLE) && id_valid_i && !flush_i && !mem_stall_i;

  ex_lat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (cnt_clear),
    .load_i    (cnt_load),
    .load_val_i(cnt_load_val),
    .dec_i     (cnt_dec),
    .zero_o    (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    unit_start_d = 1'b0;
    unit_sel_d   = unit_sel_q;
    unit_abort_d = 1'b0;
    ex_valid_d   = 1'b0;
    capture      = 1'b0;
    cnt_clear    = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = (id_op_i == OP_MUL) ? MUL_LOAD : DIV_LOAD;

    // Flush overrides everything, including a completion in the same cycle.
    if (flush_i) begin
      state_d      = IDLE;
      cnt_clear    = 1'b1;
      unit_abort_d = (state_q != IDLE);
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (id_op_i == OP_SINGLE) begin
              ex_valid_d = 1'b1;
            end else begin
              cnt_load     = 1'b1;
              unit_sel_d   = (id_op_i != OP_MUL);
              unit_start_d = 1'b1;
              state_d      = RUN;
            end
          end
        end
        RUN: begin
          if (cnt_zero) begin
            if (!mem_stall_i) begin
              capture    = 1'b1;
              ex_valid_d = 1'b1;
              state_d    = IDLE;
            end else begin
              state_d = HOLD;
            end
          end else begin
            cnt_dec = 1'b1;
          end
        end
        HOLD: begin
          if (!mem_stall_i) begin
            capture    = 1'b1;
            ex_valid_d = 1'b1;
            state_d    = IDLE;
          end
        end
        default: begin
          state_d   = IDLE;
          cnt_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      unit_start_q <= 1'b0;
      unit_sel_q   <= 1'b0;
      unit_abort_q <= 1'b0;
      ex_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      unit_start_q <= unit_start_d;
      unit_sel_q   <= unit_sel_d;
      unit_abort_q <= unit_abort_d;
      ex_valid_q   <= ex_valid_d;
    end
  end

  assign busy_o           = (state_q != IDLE);
  assign ex_stall_o       = (state_q != IDLE) || mem_stall_i;
  assign result_capture_o = capture;
  assign unit_start_o     = unit_start_q;
  assign unit_sel_o       = unit_sel_q;
  assign unit_abort_o     = unit_abort_q;
  assign ex_valid_o       = ex_valid_q;

endmodule

// File: tb/tb_ex_mc_ctrl.sv
// Scenario bench for ex_mc_ctrl: expected completion cycles are queued at issue
// and matched against every ex_valid_o pulse.
module tb_ex_mc_ctrl;

  localparam logic [1:0] OP_SINGLE = 2'b00;
  localparam logic [1:0] OP_MUL    = 2'b01;
  localparam logic [1:0] OP_DIV    = 2'b10;
  localparam logic [1:0] OP_REM    = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid_i = 1'b0;
  logic [1:0] id_op_i = 2'b00;
  logic       flush_i = 1'b0;
  logic       mem_stall_i = 1'b0;
  logic       ex_stall_o, busy_o, unit_start_o, unit_sel_o;
  logic       unit_abort_o, result_capture_o, ex_valid_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_q[$];

  ex_mc_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid_i      (id_valid_i),
    .id_op_i         (id_op_i),
    .flush_i         (flush_i),
    .mem_stall_i     (mem_stall_i),
    .ex_stall_o      (ex_stall_o),
    .busy_o          (busy_o),
    .unit_start_o    (unit_start_o),
    .unit_sel_o      (unit_sel_o),
    .unit_abort_o    (unit_abort_o),
    .result_capture_o(result_capture_o),
    .ex_valid_o      (ex_valid_o)
  );

  always #5 clk = ~clk;

  // Advance one cycle and match any completion pulse against the scoreboard.
  task automatic tick();
    int e;
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() > 0 && exp_q[0] < cyc) begin
      checks++; failures++;
      $display("FAIL sb_missed ex_valid_o expected at cycle %0d, not seen by cycle %0d", exp_q[0], cyc);
      void'(exp_q.pop_front());
    end
    if (ex_valid_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected ex_valid_o=1 at cycle %0d, required none", cyc);
      end else begin
        e = exp_q.pop_front();
        if (e != cyc) begin
          failures++;
          $display("FAIL sb_cycle ex_valid_o at cycle %0d, required cycle %0d", cyc, e);
        end else begin
          $display("completion at cycle %0d", cyc);
        end
      end
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if (unit_start_o !== 1'b0) begin failures++; $display("FAIL rst_start got %b want 0", unit_start_o); end
    checks++; if (unit_sel_o !== 1'b0) begin failures++; $display("FAIL rst_sel got %b want 0", unit_sel_o); end
    checks++; if (unit_abort_o !== 1'b0) begin failures++; $display("FAIL rst_abort got %b want 0", unit_abort_o); end
    checks++; if (ex_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got %b want 0", ex_valid_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got %b want 0", busy_o); end
    checks++; if (ex_stall_o !== 1'b0) begin failures++; $display("FAIL rst_stall got %b want 0", ex_stall_o); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int t = cyc;
    id_valid_i = 1'b1; id_op_i = OP_SINGLE;
    #1;
    checks++; if (ex_stall_o !== 1'b0) begin failures++; $display("FAIL single_stall_T got %b want 0", ex_stall_o); end
    exp_q.push_back(t + 1);
    $display("issue single at cycle %0d", t);
    tick();
    id_valid_i = 1'b0;
    #1;
    checks++; if (ex_valid_o !== 1'b1) begin failures++; $display("FAIL single_valid got %b want 1", ex_valid_o); end
    checks++; if (unit_start_o !== 1'b0) begin failures++; $display("FAIL single_start got %b want 0", unit_start_o); end
    checks++; if (ex_stall_o !== 1'b0) begin failures++; $display("FAIL single_stall got %b want 0", ex_stall_o); end
    tick();
    checks++; if (ex_valid_o !== 1'b0) begin failures++; $display("FAIL single_valid_T2 got %b want 0", ex_valid_o); end
  endtask

  task automatic test_mul();
    int t = cyc;
    id_valid_i = 1'b1; id_op_i = OP_MUL;
    #1;
    checks++; if (ex_stall_o !== 1'b0) begin failures++; $display("FAIL mul_accept_stall got %b want 0", ex_stall_o); end
    exp_q.push_back(t + 5);
    $display("issue mul at cycle %0d", t);
    tick();
    id_op_i = OP_SINGLE;
    #1;
    checks++; if (unit_start_o !== 1'b1) begin failures++; $display("FAIL mul_start got %b want 1", unit_start_o); end
    checks++; if (unit_sel_o !== 1'b0) begin failures++; $display("FAIL mul_sel got %b want 0", unit_sel_o); end
    checks++; if (ex_stall_o !== 1'b1) begin failures++; $display("FAIL mul_stall_1 got %b want 1", ex_stall_o); end
    checks++; if (result_capture_o !== 1'b0) begin failures++; $display("FAIL mul_cap_1 got %b want 0", result_capture_o); end
    for (int k = 2; k <= 4; k++) begin
      tick();
      #1;
      checks++; if (ex_stall_o !== 1'b1) begin failures++; $display("FAIL mul_stall_%0d got %b want 1", k, ex_stall_o); end
      checks++; if (unit_start_o !== 1'b0) begin failures++; $display("FAIL mul_start_%0d got %b want 0", k, unit_start_o); end
      checks++; if (result_capture_o !== (k == 4)) begin failures++; $display("FAIL mul_cap_%0d got %b want %b", k, result_capture_o, (k == 4)); end
    end
    tick();
    #1;
    checks++; if (ex_valid_o !== 1'b1) begin failures++; $display("FAIL mul_valid got %b want 1", ex_valid_o); end
    checks++; if (ex_stall_o !== 1'b0) begin failures++; $display("FAIL mul_next_accept_stall got %b want 0", ex_stall_o); end
    exp_q.push_back(t + 6);
    $display("issue single at cycle %0d", cyc);
    tick();
    id_valid_i = 1'b0;
    #1;
    checks++; if (ex_valid_o !== 1'b1) begin failures++; $display("FAIL mul_follow_valid got %b want 1", ex_valid_o); end
    tick();
  endtask

  task automatic test_div_hold();
    int t = cyc;
    id_valid_i = 1'b1; id_op_i = OP_DIV;
    #1;
    exp_q.push_back(t + 38);
    $display("issue div at cycle %0d", t);
    tick();
    id_valid_i = 1'b0;
    for (int k = 1; k <= 37; k++) begin
      if (k > 1) tick();
      mem_stall_i = (k >= 30 && k <= 36);
      #1;
      if (k == 1) begin
        checks++; if (unit_start_o !== 1'b1) begin failures++; $display("FAIL div_start got %b want 1", unit_start_o); end
        checks++; if (unit_sel_o !== 1'b1) begin failures++; $display("FAIL div_sel got %b want 1", unit_sel_o); end
      end
      checks++; if (ex_stall_o !== 1'b1) begin failures++; $display("FAIL div_stall_%0d got %b want 1", k, ex_stall_o); end
      checks++; if (result_capture_o !== (k == 37)) begin failures++; $display("FAIL div_cap_%0d got %b want %b", k, result_capture_o, (k == 37)); end
    end
    tick();
    mem_stall_i = 1'b0;
    #1;
    checks++; if (ex_valid_o !== 1'b1) begin failures++; $display("FAIL div_valid got %b want 1", ex_valid_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL div_busy_end got %b want 0", busy_o); end
    checks++; if (ex_stall_o !== 1'b0) begin failures++; $display("FAIL div_stall_end got %b want 0", ex_stall_o); end
    tick();
  endtask

  task automatic test_flush_rem();
    int t = cyc;
    id_valid_i = 1'b1; id_op_i = OP_REM;
    #1;
    $display("issue rem at cycle %0d (flushed)", t);
    tick();
    id_valid_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) tick();
      if (k == 10) flush_i = 1'b1;
      #1;
      if (k == 1) begin
        checks++; if (unit_sel_o !== 1'b1) begin failures++; $display("FAIL rem_sel got %b want 1", unit_sel_o); end
      end
      checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL rem_busy_%0d got %b want 1", k, busy_o); end
    end
    tick();
    flush_i = 1'b0;
    id_valid_i = 1'b1; id_op_i = OP_MUL;
    #1;
    checks++; if (unit_abort_o !== 1'b1) begin failures++; $display("FAIL rem_abort got %b want 1", unit_abort_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rem_idle got %b want 0", busy_o); end
    checks++; if (ex_stall_o !== 1'b0) begin failures++; $display("FAIL rem_accept_stall got %b want 0", ex_stall_o); end
    exp_q.push_back(t + 16);
    $display("issue mul at cycle %0d", cyc);
    tick();
    id_valid_i = 1'b0;
    #1;
    checks++; if (unit_start_o !== 1'b1) begin failures++; $display("FAIL rem_mul_start got %b want 1", unit_start_o); end
    checks++; if (unit_abort_o !== 1'b0) begin failures++; $display("FAIL rem_abort_clr got %b want 0", unit_abort_o); end
    checks++; if (unit_sel_o !== 1'b0) begin failures++; $display("FAIL rem_mul_sel got %b want 0", unit_sel_o); end
    repeat (5) tick();
  endtask

  task automatic test_flush_complete();
    int t = cyc;
    id_valid_i = 1'b1; id_op_i = OP_MUL;
    #1;
    $display("issue mul at cycle %0d (flushed at completion)", t);
    tick();
    id_valid_i = 1'b0;
    repeat (3) tick();
    flush_i = 1'b1;
    #1;
    checks++; if (result_capture_o !== 1'b0) begin failures++; $display("FAIL fc_cap got %b want 0", result_capture_o); end
    tick();
    flush_i = 1'b0;
    #1;
    checks++; if (unit_abort_o !== 1'b1) begin failures++; $display("FAIL fc_abort got %b want 1", unit_abort_o); end
    checks++; if (ex_valid_o !== 1'b0) begin failures++; $display("FAIL fc_valid got %b want 0", ex_valid_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL fc_busy got %b want 0", busy_o); end
    tick();
    checks++; if (unit_abort_o !== 1'b0) begin failures++; $display("FAIL fc_abort_clr got %b want 0", unit_abort_o); end
  endtask

  task automatic test_reset_mid();
    int t = cyc;
    id_valid_i = 1'b1; id_op_i = OP_DIV;
    #1;
    $display("issue div at cycle %0d (reset mid-run)", t);
    tick();
    id_valid_i = 1'b0;
    repeat (15) tick();
    rst = 1'b0;
    #1;
    checks++; if (unit_sel_o !== 1'b0) begin failures++; $display("FAIL rm_sel got %b want 0", unit_sel_o); end
    checks++; if (unit_start_o !== 1'b0) begin failures++; $display("FAIL rm_start got %b want 0", unit_start_o); end
    checks++; if (unit_abort_o !== 1'b0) begin failures++; $display("FAIL rm_abort got %b want 0", unit_abort_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rm_busy got %b want 0", busy_o); end
    checks++; if (ex_stall_o !== 1'b0) begin failures++; $display("FAIL rm_stall got %b want 0", ex_stall_o); end
    tick();
    rst = 1'b1;
    tick();
    checks++; if (unit_abort_o !== 1'b0) begin failures++; $display("FAIL rm_abort_after got %b want 0", unit_abort_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rm_busy_after got %b want 0", busy_o); end
    repeat (40) tick();
  endtask

  task automatic test_back_to_back();
    test_single();
    test_single();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sb_leftover got %0d entries want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mul();
    test_div_hold();
    test_flush_rem();
    test_flush_complete();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
